// File: rtl/sumador_pkg.sv
// Shared types and helpers for the digit-serial adder-subtractor.
// Holds the FSM state type, op encoding and the counter width helper.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int cnt_w(
    input int width,
    input int digit
  );
    int n;
    n = width / digit;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sumador_digito.sv
// One DIGIT-bit ripple slice of the serial adder-subtractor.
// Also exposes the carry into its MSB so the top can derive overflow.
module sumador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic c;

  // Ripple through the slice, remembering the carry entering the top bit
  always_comb begin
    s    = '0;
    c    = ci;
    cmsb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/sumador_restador_serie.sv
// Digit-serial signed/unsigned adder-subtractor with valid/ready on both sides.
// Optional SUMRES_SAT_EN clamps an overflowing result to the signed limit.
module sumador_restador_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH
      || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("sumador_restador_serie: bad WIDTH/DIGIT");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [WIDTH-1:0] s_nxt, s_fin;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q, zero_q, neg_q;

  logic [DIGIT-1:0] da, db, ds;
  logic             dco, dcm;
  logic             acc, busy, last, ovf_fin;

  assign acc  = (state_q == IDLE) && in_valid;
  assign busy = (state_q == BUSY);
  assign last = (cnt_q == LAST);

  assign da = a_q[cnt_q*DIGIT +: DIGIT];
  assign db = b_q[cnt_q*DIGIT +: DIGIT];

  sumador_digito #(
    .DIGIT(DIGIT)
  ) u_dig (
    .a    (da),
    .b    (db),
    .ci   (c_q),
    .s    (ds),
    .co   (dco),
    .cmsb (dcm)
  );

  // Merge the current digit into the result and form the final value
  always_comb begin
    s_nxt = s_q;
    s_nxt[cnt_q*DIGIT +: DIGIT] = ds;
    ovf_fin = dco ^ dcm;
    s_fin = s_nxt;
`ifdef SUMRES_SAT_EN
    if (ovf_fin) begin
      s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, serial datapath and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (acc) begin
        a_q   <= a;
        b_q   <= (sub == OP_SUB) ? ~b : b;
        c_q   <= (sub == OP_SUB) ? ~cin : cin;
        cnt_q <= '0;
      end
      if (busy) begin
        s_q <= s_nxt;
        c_q <= dco;
        if (!last) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          s_q    <= s_fin;
          cout_q <= dco;
          ovf_q  <= ovf_fin;
          zero_q <= (s_fin == '0);
          neg_q  <= s_fin[WIDTH-1];
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: doc/sumador_restador_serie.md
# sumador_restador_serie

Parametrised, digit-serial signed/unsigned adder-subtractor with carry/borrow chaining, status flags and a valid/ready handshake on both sides. It is the successor of the fixed 4-bit combinational SumadorRestador. It is generalised to WIDTH bits and processes DIGIT bits per clock through a registered carry. It sits between operand registers and the result bus of the lab datapath, and any producer/consumer pair with backpressure can drive it.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH ≥ 2.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A−B−cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  result.
- cout  output  1  carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  s == 0.
- neg  output  1  s[WIDTH-1].

## Operation
- Arithmetic: s = A + (sub ? ~B : B) + (sub ? ~cin : cin), modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
- ovf = (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), where B' is the effective (possibly inverted) B.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b', the effective carry-in and sub, clear the digit counter, and go to BUSY.
  - BUSY: each cycle, add digit k of A and B' plus the registered carry; write the result into s[k·DIGIT +: DIGIT] and update the carry. After digit N−1 (N = WIDTH/DIGIT), register cout/ovf/zero/neg and go to DONE.
  - DONE: out_valid=1. s and the flags stay stable until out_valid && out_ready, then go to IDLE.
- Inputs are ignored outside IDLE. in_ready = (state == IDLE) exactly.
- Operands are sampled only at the accept edge. Later changes on a/b/cin/sub have no effect on the operation in flight.
- Reset (any time, including mid-BUSY or DONE) asserts asynchronously and aborts the operation. State goes to IDLE; s, cout, ovf, zero, neg and out_valid go to 0; the carry and digit counter clear.

## Timing
- Accept at edge k (in_valid && in_ready). Digits are processed at edges k+1 … k+N. out_valid rises after edge k+N.
- Latency is N cycles from accept to out_valid.
- Minimum initiation interval is N+2 cycles: one DONE cycle plus one IDLE cycle.
- out_valid, once high, stays high with stable outputs until the out handshake edge. It falls after that edge.
- in_ready is high during reset and in IDLE. It falls the cycle after accept.
- The digit counter saturates at N−1; there is no wrap. The carry is never carried across operations.

## Configuration
- SUMRES_SAT_EN defined: when ovf=1 on the final digit, s is clamped to the signed limit. If A is non-negative, s = 0x7F…F; if A is negative, s = 0x80…0. ovf still reports 1. zero and neg reflect the clamped s. cout is unchanged.
- Not defined: s wraps modulo 2^WIDTH, and no clamp logic is built.

## Structure
- sumador_pkg holds:
  - the FSM state typedef (IDLE, BUSY, DONE);
  - the op encoding constants (OP_ADD=0, OP_SUB=1);
  - a function computing the counter width as $clog2(WIDTH/DIGIT), minimum 1.
- Sub-module sumador_digito is combinational and DIGIT bits wide, with inputs a, b, ci and outputs s, co, plus the MSB carry-in for ovf. It is instantiated once and reused across cycles.

## Test plan
- WIDTH=16, DIGIT=4, add 0x0003 + 0x0001, cin=1 -> s=0x0005, cout=0, ovf=0, zero=0, neg=0; out_valid exactly 4 cycles after accept.
- sub 0x0003 − 0x0003, cin=0 -> s=0x0000, zero=1, cout=1 (no borrow), ovf=0; sub 0x0000 − 0x0001 -> s=0xFFFF, cout=0, neg=1.
- add 0x7FFF + 0x0001, cin=0 -> ovf=1; s=0x8000, neg=1 without SUMRES_SAT_EN; s=0x7FFF, neg=0 with it.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while driving new in_valid with different operands -> s and flags constant, in_ready=0, new operands not accepted. out_ready=1 -> out_valid low next cycle, in_ready high.
- Reset: pulse rst_n low at the second BUSY cycle -> out_valid, s, and flags 0 immediately (asynchronous). After release, in_ready=1 and the next operation's result is correct.
- WIDTH=8, DIGIT=8: 0xFF + 0x01, cin=0 -> s=0x00, cout=1, zero=1, ovf=0; latency 1 cycle.
